// File: rtl/div_pkg.sv
// Shared types and helpers for the divider arbiter: FSM state encoding,
// the registered response record and a two's-complement negate helper.
package div_pkg;

  localparam int MAX_W   = 64;
  localparam int MAX_IDW = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_ITER,
    S_FIX,
    S_RESP
  } state_e;

  // Fields are sized for the widest supported configuration; users take the low bits.
  typedef struct packed {
    logic [MAX_IDW-1:0] id;
    logic [MAX_W-1:0]   q;
    logic [MAX_W-1:0]   r;
    logic               dbz;
    logic               ovf;
  } rsp_t;

  // Low bits of the result are a correct negate/magnitude for any narrower operand.
  function automatic logic [MAX_W-1:0] neg_if(input logic neg, input logic [MAX_W-1:0] v);
    return neg ? (~v + MAX_W'(1)) : v;
  endfunction

endpackage

// File: rtl/div_arb_if.sv
// Request/response bundle between the requesters (ALU, microcode sequencer)
// and the shared divider arbiter.
interface div_arb_if #(
  parameter int DSZ = 32,
  parameter int NR  = 2,
  parameter int IDW = (NR > 1) ? $clog2(NR) : 1
);
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*DSZ-1:0] req_x;
  logic [NR*DSZ-1:0] req_y;
  logic [NR-1:0]     req_sgn;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IDW-1:0]    rsp_id;
  logic [DSZ-1:0]    rsp_q;
  logic [DSZ-1:0]    rsp_r;
  logic              rsp_dbz;
  logic              rsp_ovf;

  modport master (
    output req_valid, req_x, req_y, req_sgn, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz, rsp_ovf
  );

  modport slave (
    input  req_valid, req_x, req_y, req_sgn, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_q, rsp_r, rsp_dbz, rsp_ovf
  );
endinterface

// File: rtl/div_int.sv
// Unsigned restoring divider, one quotient bit per cycle. Loads while start
// is high and free-runs afterwards; the result is valid DSZ cycles after load.
module div_int #(
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           start,
  input  logic [DSZ-1:0] x,
  input  logic [DSZ-1:0] y,
  output logic [DSZ-1:0] q,
  output logic [DSZ-1:0] r
);
  logic [DSZ-1:0] rem_q, rem_d;
  logic [DSZ-1:0] quo_q, quo_d;
  logic [DSZ-1:0] den_q, den_d;
  logic [DSZ:0]   trial;
  logic [DSZ:0]   diff;

  always_comb begin
    trial = {rem_q, quo_q[DSZ-1]};
    diff  = trial - {1'b0, den_q};
    rem_d = rem_q;
    quo_d = quo_q;
    den_d = den_q;
    if (start) begin
      rem_d = '0;
      quo_d = x;
      den_d = y;
    end else if (!diff[DSZ]) begin
      // trial >= divisor: keep the difference and shift in a 1
      rem_d = diff[DSZ-1:0];
      quo_d = {quo_q[DSZ-2:0], 1'b1};
    end else begin
      rem_d = trial[DSZ-1:0];
      quo_d = {quo_q[DSZ-2:0], 1'b0};
    end
  end

  always_ff @(posedge clk) begin
    rem_q <= rem_d;
    quo_q <= quo_d;
    den_q <= den_d;
  end

  assign q = quo_q;
  assign r = rem_q;
endmodule

// File: rtl/div_arb.sv
// Round-robin arbiter sharing one iterative divider among NR requesters,
// with optional signed (truncate-toward-zero) operation around the unsigned core.
module div_arb
  import div_pkg::*;
#(
  parameter int DSZ = 32,
  parameter int NR  = 2,
  parameter int IDW = (NR > 1) ? $clog2(NR) : 1
) (
  input  logic       clk,
  input  logic       rst,
  div_arb_if.slave   bus,
  output logic       busy
);
  localparam int             CW    = (DSZ > 1) ? $clog2(DSZ) : 1;
  localparam logic [DSZ-1:0] MIN_V = {1'b1, {(DSZ-1){1'b0}}};

  state_e         state_q, state_d;
  logic [IDW-1:0] ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] id_q, id_d;
  logic           sgn_q, sgn_d, sx_q, sx_d, sy_q, sy_d;
  logic [DSZ-1:0] xm_q, xm_d, ym_q, ym_d;
  rsp_t           rsp_q, rsp_d;

  logic           gnt_any;
  logic [IDW-1:0] gnt_id;
  logic [DSZ-1:0] gnt_x, gnt_y;
  logic           gnt_sgn;
  logic [DSZ-1:0] core_q, core_r;
  int             idx;

  // First valid requester at or after the pointer, wrapping
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    idx     = 0;
    for (int k = 0; k < NR; k++) begin
      idx = (int'(ptr_q) + k) % NR;
      if (!gnt_any && bus.req_valid[idx]) begin
        gnt_any = 1'b1;
        gnt_id  = IDW'(idx);
      end
    end
  end

  assign gnt_x   = bus.req_x[int'(gnt_id)*DSZ +: DSZ];
  assign gnt_y   = bus.req_y[int'(gnt_id)*DSZ +: DSZ];
  assign gnt_sgn = bus.req_sgn[gnt_id];

  always_comb begin
    bus.req_ready = '0;
    if (state_q == S_IDLE && gnt_any) bus.req_ready[gnt_id] = 1'b1;
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    id_d    = id_q;
    sgn_d   = sgn_q;
    sx_d    = sx_q;
    sy_d    = sy_q;
    xm_d    = xm_q;
    ym_d    = ym_q;
    rsp_d   = rsp_q;
    case (state_q)
      S_IDLE: if (gnt_any) begin
        id_d  = gnt_id;
        sgn_d = gnt_sgn;
        sx_d  = gnt_sgn & gnt_x[DSZ-1];
        sy_d  = gnt_sgn & gnt_y[DSZ-1];
        xm_d  = DSZ'(neg_if(sx_d, MAX_W'(gnt_x)));
        ym_d  = DSZ'(neg_if(sy_d, MAX_W'(gnt_y)));
        ptr_d = IDW'((int'(gnt_id) + 1) % NR);
        if (gnt_y == '0) begin
          // Divide by zero bypasses the core entirely
          rsp_d.id  = MAX_IDW'(gnt_id);
          rsp_d.q   = MAX_W'({DSZ{1'b1}});
          rsp_d.r   = MAX_W'(gnt_x);
          rsp_d.dbz = 1'b1;
          rsp_d.ovf = 1'b0;
          state_d   = S_RESP;
        end else begin
          state_d = S_START;
        end
      end
      S_START: begin
        cnt_d   = '0;
        state_d = S_ITER;
      end
      S_ITER: begin
        if (cnt_q == CW'(DSZ-1)) state_d = S_FIX;
        else                     cnt_d   = cnt_q + 1'b1;
      end
      S_FIX: begin
        // min / -1 falls out naturally as q=min, r=0; only the flag is extra
        rsp_d.id  = MAX_IDW'(id_q);
        rsp_d.q   = neg_if(sx_q ^ sy_q, MAX_W'(core_q));
        rsp_d.r   = neg_if(sx_q, MAX_W'(core_r));
        rsp_d.dbz = 1'b0;
        rsp_d.ovf = sgn_q & sx_q & sy_q & (xm_q == MIN_V) & (ym_q == DSZ'(1));
        state_d   = S_RESP;
      end
      S_RESP: if (bus.rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    id_q  <= id_d;
    sgn_q <= sgn_d;
    sx_q  <= sx_d;
    sy_q  <= sy_d;
    xm_q  <= xm_d;
    ym_q  <= ym_d;
    rsp_q <= rsp_d;
  end

  div_int #(.DSZ(DSZ)) u_div_int (
    .clk   (clk),
    .start (rst | (state_q == S_START)),
    .x     (xm_q),
    .y     (ym_q),
    .q     (core_q),
    .r     (core_r)
  );

  assign busy          = (state_q != S_IDLE);
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_id    = bus.rsp_valid ? IDW'(rsp_q.id) : '0;
  assign bus.rsp_q     = bus.rsp_valid ? DSZ'(rsp_q.q)  : '0;
  assign bus.rsp_r     = bus.rsp_valid ? DSZ'(rsp_q.r)  : '0;
  assign bus.rsp_dbz   = bus.rsp_valid & rsp_q.dbz;
  assign bus.rsp_ovf   = bus.rsp_valid & rsp_q.ovf;
endmodule

// File: tb/tb_div_arb.sv
// Scoreboard bench for div_arb: requests are modelled with plain arithmetic
// at grant time, and a separate monitor checks every presented response.
`timescale 1ns/1ps
module tb_div_arb;
  localparam int DSZ = 32;
  localparam int NR  = 2;
  localparam int IDW = 1;

  typedef struct {
    int          id;
    logic [31:0] q;
    logic [31:0] r;
    bit          dbz;
    bit          ovf;
    int          hs;
    int          lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic busy;

  div_arb_if #(.DSZ(DSZ), .NR(NR), .IDW(IDW)) bus ();

  div_arb #(.DSZ(DSZ), .NR(NR), .IDW(IDW)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0;
  int          n_bad = 0;
  exp_t        sb[$];
  int          gseq[$];
  bit          pv[NR];
  bit          ps[NR];
  logic [31:0] px[NR];
  logic [31:0] py[NR];
  int          gnt_last  = -1;
  int          rr_ptr    = 0;
  int          auto_left = 0;
  int          rand_left = 0;
  bit          rdy_rand  = 0;
  bit          hold_next = 0;
  int          hold_cnt  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic exp_t model(input int id, input logic [31:0] x, input logic [31:0] y, input bit s);
    exp_t   e;
    longint a, b, qq, rr;
    e.id = id; e.dbz = 0; e.ovf = 0; e.hs = 0; e.lat = DSZ + 3;
    if (y == 0) begin
      e.q = 32'hFFFF_FFFF; e.r = x; e.dbz = 1; e.lat = 1;
    end else if (!s) begin
      e.q = x / y; e.r = x % y;
    end else begin
      a  = longint'($signed(x));
      b  = longint'($signed(y));
      qq = a / b;
      rr = a % b;
      e.q = qq[31:0];
      e.r = rr[31:0];
      e.ovf = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    end
    return e;
  endfunction

  task automatic arm(input int i, input logic [31:0] x, input logic [31:0] y, input bit s);
    pv[i] = 1; px[i] = x; py[i] = y; ps[i] = s;
  endtask

  task automatic arm_rand(input int i);
    logic [31:0] x, y;
    case ($urandom % 8)
      0:       y = 32'd0;
      1:       y = 32'hFFFF_FFFF;
      2:       y = $urandom % 16;
      default: y = $urandom;
    endcase
    x = ($urandom % 8 == 0) ? 32'h8000_0000 : $urandom;
    arm(i, x, y, bit'($urandom % 2));
  endtask

  task automatic drive();
    for (int i = 0; i < NR; i++) begin
      bus.req_valid[i]           = pv[i];
      bus.req_sgn[i]             = ps[i];
      bus.req_x[i*DSZ +: DSZ]    = px[i];
      bus.req_y[i*DSZ +: DSZ]    = py[i];
    end
  endtask

  task automatic observe();
    int   hs, exp_id, j;
    exp_t e;
    hs = -1; exp_id = -1;
    for (int i = 0; i < NR; i++)
      if (bus.req_valid[i] && bus.req_ready[i]) hs = i;
    if (hs >= 0) begin
      for (int k = 0; k < NR; k++) begin
        j = (rr_ptr + k) % NR;
        if (exp_id < 0 && pv[j]) exp_id = j;
      end
      chk("grant", 64'(bus.req_ready), 64'(1) << exp_id);
      e = model(hs, px[hs], py[hs], ps[hs]);
      e.hs = cyc;
      sb.push_back(e);
      rr_ptr   = (hs + 1) % NR;
      gnt_last = hs;
      gseq.push_back(hs);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
    if (gnt_last >= 0) begin pv[gnt_last] = 0; gnt_last = -1; end
    for (int i = 0; i < NR; i++) begin
      if (!pv[i]) begin
        if (auto_left > 0) begin arm_rand(i); auto_left--; end
        else if (rand_left > 0 && $urandom % 3 == 0) begin arm_rand(i); rand_left--; end
      end
    end
    if (hold_next && bus.rsp_valid) begin hold_cnt = 5; hold_next = 0; end
    if (hold_cnt > 0) begin bus.rsp_ready = 1'b0; hold_cnt--; end
    else bus.rsp_ready = rdy_rand ? ($urandom % 3 != 0) : 1'b1;
    drive();
    @(negedge clk);
    if (!rst) observe();
  endtask

  function automatic bit any_pending();
    bit a = 0;
    for (int i = 0; i < NR; i++) a |= pv[i];
    return a;
  endfunction

  task automatic drain(input int budget);
    int n = 0;
    while ((sb.size() != 0 || any_pending() || auto_left > 0 || rand_left > 0 || busy) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) chk("drain_timeout", 1, 0);
  endtask

  task automatic run_op(input int i, input logic [31:0] x, input logic [31:0] y, input bit s);
    arm(i, x, y, s);
    drain(200);
  endtask

  // Response monitor
  bit          prev_v = 0, prev_hold = 0;
  logic [31:0] sv_q, sv_r;
  logic [3:0]  sv_misc;
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      prev_v = 0; prev_hold = 0;
    end else begin
      if (prev_hold) begin
        chk("hold_valid", 64'(bus.rsp_valid), 1);
        chk("hold_qr", {bus.rsp_q, bus.rsp_r}, {sv_q, sv_r});
        chk("hold_misc", 64'({bus.rsp_id, bus.rsp_dbz, bus.rsp_ovf}), 64'(sv_misc));
      end
      if (bus.rsp_valid) chk("no_grant_in_resp", 64'(bus.req_ready), 0);
      if (bus.rsp_valid && !prev_v) begin
        if (sb.size() == 0) chk("unexpected_rsp", 1, 0);
        else chk("latency", 64'(cyc - sb[0].hs), 64'(sb[0].lat));
      end
      if (bus.rsp_valid && bus.rsp_ready) begin
        if (sb.size() == 0) chk("rsp_no_expect", 1, 0);
        else begin
          e = sb.pop_front();
          chk("rsp_id",  64'(bus.rsp_id),  64'(e.id));
          chk("rsp_q",   64'(bus.rsp_q),   64'(e.q));
          chk("rsp_r",   64'(bus.rsp_r),   64'(e.r));
          chk("rsp_dbz", 64'(bus.rsp_dbz), 64'(e.dbz));
          chk("rsp_ovf", 64'(bus.rsp_ovf), 64'(e.ovf));
        end
      end
      prev_v    = bus.rsp_valid;
      prev_hold = bus.rsp_valid && !bus.rsp_ready;
      sv_q      = bus.rsp_q;
      sv_r      = bus.rsp_r;
      sv_misc   = {2'b00, bus.rsp_id, bus.rsp_dbz, bus.rsp_ovf} ;
    end
  end

  initial begin
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int a, n, g0;
    for (int i = 0; i < NR; i++) arm(i, 0, 0, 0);
    for (int i = 0; i < NR; i++) pv[i] = 0;
    drive();
    bus.rsp_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", 64'(bus.req_ready), 0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 0);
    chk("rst_busy",      64'(busy), 0);
    chk("rst_rsp_q",     64'(bus.rsp_q), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Both requesters continuously valid for four operations; first response back-pressured
    hold_next = 1;
    arm_rand(0);
    arm_rand(1);
    auto_left = 2;
    drain(600);
    chk("arb_count", 64'(gseq.size()), 4);
    for (int i = 0; i < 4 && i < gseq.size(); i++)
      chk("arb_order", 64'(gseq[i]), 64'(i % 2));

    run_op(0, 32'd100, 32'd7, 0);
    run_op(1, 32'hFFFF_FFF9, 32'd2, 1);
    run_op(1, 32'd7, 32'hFFFF_FFFE, 1);
    run_op(0, 32'h0000_1234, 32'd0, 0);
    run_op(1, 32'h8000_0000, 32'hFFFF_FFFF, 1);
    run_op(0, 32'h8000_0000, 32'hFFFF_FFFF, 0);

    // Abort an operation in flight with reset
    g0 = gseq.size();
    arm(0, 32'd123456, 32'd789, 0);
    n = 0;
    while (gseq.size() == g0 && n < 20) begin step(); n++; end
    if (gseq.size() == g0) chk("abort_grant_timeout", 1, 0);
    a = cyc;
    while (cyc < a + 9) step();
    chk("abort_busy_before", 64'(busy), 1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    sb.delete();
    rr_ptr = 0;
    gnt_last = -1;
    for (int i = 0; i < NR; i++) pv[i] = 0;
    drive();
    @(negedge clk);
    chk("abort_busy",      64'(busy), 0);
    chk("abort_rsp_valid", 64'(bus.rsp_valid), 0);
    run_op(1, 32'd1000, 32'd33, 0);

    // Random traffic with random response back-pressure
    rdy_rand  = 1;
    rand_left = 60;
    drain(8000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/div_arb.md
Name: div_arb

Overview:
- Shares one iterative integer divider (div_int) among NR requesters.
- Round-robin arbitration over per-requester valid/ready request ports.
- Optional signed mode, truncating toward zero; signs are converted around the unsigned core.
- Sequences the divider start pulse and iteration count, then returns quotient/remainder on one shared response channel tagged with the requester id.
- Sits between the ALU/microcode sequencer ports and the divider.

Parameters:
- DSZ, 32, operand/result width.
- NR, 2, number of requesters (≥1).
- IDW, $clog2(NR) (min 1), requester id width.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- req_valid  in  NR  per-requester request valid
- req_ready  out  NR  one-hot grant; a handshake occurs when valid&ready
- req_x  in  NR*DSZ  dividends, requester i at [i*DSZ +: DSZ]
- req_y  in  NR*DSZ  divisors, same packing
- req_sgn  in  NR  1 = signed two's-complement operation
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_id  out  IDW  requester index of the response
- rsp_q  out  DSZ  quotient
- rsp_r  out  DSZ  remainder
- rsp_dbz  out  1  divide by zero
- rsp_ovf  out  1  signed overflow (min / -1)
- busy  out  1  high in any state other than IDLE

Behaviour:
- FSM states: IDLE, START, ITER, FIX, RESP. On rst: state=IDLE, rr pointer=0, iteration count=0. All rsp_* outputs and req_ready are 0; busy=0.
- Reset mid-operation aborts the operation. The divider start line is held asserted while rst is high.
- IDLE
  - req_ready is one-hot for the first valid requester at or after the pointer, wrapping modulo NR. It is combinational and only asserted in IDLE. req_ready=0 when no requester is valid.
  - On handshake, latch the id, the sign flag, and the magnitudes |x| and |y| (negate only when sgn=1 and MSB=1). Latch sx = sgn&x[MSB] and sy = sgn&y[MSB].
  - Pointer ← granted id + 1 (mod NR).
  - y==0: go to RESP with q=all ones, r=x (raw), dbz=1, ovf=0, skipping the divider.
  - Otherwise go to START.
- START: assert the divider start for exactly 1 cycle with the magnitudes applied; clear the counter; go to ITER.
- ITER: stay exactly DSZ cycles (count 0..DSZ-1); operands are held stable. The divider result is sampled only in the cycle after the last ITER cycle, because the core free-runs afterwards.
- FIX
  - Capture core q/r.
  - Negate q if sx^sy; negate r if sx.
  - ovf=1 iff sgn, x==2^(DSZ-1) and y==all ones. In that case q=2^(DSZ-1) and r=0, which is the natural result.
  - Go to RESP.
- RESP: rsp_valid=1, outputs held stable until rsp_ready. On rsp_ready, go to IDLE (next grant possible the cycle after).
- Latency from handshake cycle A:
  - START at A+1.
  - ITER at A+2..A+DSZ+1.
  - FIX at A+DSZ+2.
  - rsp_valid at A+DSZ+3 (35 for DSZ=32).
  - dbz responses arrive at A+1.
- Throughput: one operation in flight. req_ready=0 in all non-IDLE states.
- Unsigned mode: sx=sy=0, no correction.
- Simultaneous valids are resolved by round-robin. A request that drops valid before it is granted is ignored (no latching).

Decomposition:
- div_pkg holds:
  - an enum for the FSM states;
  - a response struct {id, q, r, dbz, ovf};
  - a function for two's-complement magnitude/negate.
- One sub-module: div_int (unsigned iterative core), instantiated once. The start line is driven by rst | (state==START).
- The round-robin grant logic stays inline.

Test Plan:
- Unsigned, requester 0: x=100, y=7 → rsp_id=0, q=14, r=2, dbz=0. rsp_valid exactly DSZ+3 cycles after the handshake.
- Signed, requester 1: x=-7 (0xFFFFFFF9), y=2 → q=-3 (0xFFFFFFFD), r=-1 (0xFFFFFFFF). Also x=7, y=-2 → q=-3, r=1.
- Divide by zero: x=0x1234, y=0 → dbz=1, q=0xFFFFFFFF, r=0x1234, rsp_valid at A+1.
- Overflow: signed x=0x80000000, y=0xFFFFFFFF → q=0x80000000, r=0, ovf=1. The same operands unsigned → q=0, r=0x80000000, ovf=0.
- Arbitration: both requesters hold valid for 4 operations → grants alternate 0,1,0,1. rsp_ready is held low 5 cycles on one response → outputs stable, no new grant.
- Reset mid-ITER: assert rst at cycle A+10 → busy=0, rsp_valid=0 the next cycle. A fresh request afterwards returns a correct result.
